mmio_uart_tx: RTL

- Memory-mapped UART transmitter on the core's data-access bus (acs_*), directly downstream of the cpu.
- Decodes stores to its address window and queues bytes in a TX FIFO.
- Serialises queued bytes as 8N1 frames on uart_tx.
- Returns a status word combinationally on loads, so the single-cycle core never stalls. The SoC top muxes acs_rdata between this block and RAM using sel.

---
 rtl/mmio_uart_tx_pkg.sv | 38 +++
 rtl/mmio_uart_tx_sync_fifo.sv | 76 +++++++
 rtl/mmio_uart_tx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit layout, TX FSM states and the STATUS word packer.
package mmio_uart_tx_pkg;

   localparam logic TXDATA_OFF = 1'b0;
   localparam logic STATUS_OFF = 1'b1;

   localparam int FULL    = 32'd0;
   localparam int EMPTY   = 32'd1;
   localparam int BUSY    = 32'd2;
   localparam int OVF     = 32'd3;
   localparam int CNT_LSB = 32'd8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   function automatic logic [63:0] pack_status(
      input logic       full,
      input logic       empty,
      input logic       busy,
      input logic       ovf,
      input logic [7:0] cnt
   );
      logic [63:0] s;
      s                = 64'h0;
      s[FULL]          = full;
      s[EMPTY]         = empty;
      s[BUSY]          = busy;
      s[OVF]           = ovf;
      s[CNT_LSB +: 8]  = cnt;
      return s;
   endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous circular-buffer FIFO; a push is accepted only when not full and
// a pop only when not empty, so callers may drive push/pop unconditionally.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);

   localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok_s, pop_ok_s;

   assign full_o    = (count_q == DEPTH_CNT);
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign dout_o    = mem_q[rd_ptr_q];
   assign push_ok_s = push_i && !full_o;
   assign pop_ok_s  = pop_i && !empty_o;

   // Pointer and occupancy next-state; pointers wrap naturally at DEPTH
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1'b1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1'b1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + (AW + 1)'(1'b1);
         2'b01:   count_d = count_q - (AW + 1)'(1'b1);
         default: count_d = count_q;
      endcase
   end

   // Control registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Data storage carries no reset; validity is tracked by the pointers
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores feed a TX FIFO, STATUS
// loads answer combinationally so the single-cycle core never stalls.
module mmio_uart_tx
   import mmio_uart_tx_pkg::*;
#(
   parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_a000_0000,
   parameter int          CLK_DIV    = 16,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        acs_en,
   input  logic        acs_wr,
   input  logic [7:0]  acs_bytes,
   input  logic [63:0] acs_addr,
   input  logic [63:0] acs_wdata,
   output logic [63:0] acs_rdata,
   output logic        sel,
   output logic        uart_tx
);

   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam logic [15:0] BAUD_MAX = 16'(CLK_DIV - 1);

   tx_state_e   state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;
   logic        ovf_q, ovf_d;

   logic        push_s, pop_s, ovf_clr_s, rd_status_s, baud_end_s;
   logic [7:0]  fifo_dout_s;
   logic        fifo_full_s, fifo_empty_s;
   logic [AW:0] fifo_count_s;
   logic        unused_s;

   assign sel         = acs_en && (acs_addr[63:4] == BASE_ADDR[63:4]);
   assign push_s      = sel && acs_wr && acs_bytes[0] && (acs_addr[3] == TXDATA_OFF);
   assign ovf_clr_s   = sel && acs_wr && acs_bytes[0] && (acs_addr[3] == STATUS_OFF)
                        && acs_wdata[3];
   assign rd_status_s = sel && !acs_wr && (acs_addr[3] == STATUS_OFF);
   assign baud_end_s  = (baud_q == BAUD_MAX);
   assign uart_tx     = tx_q;
   assign unused_s    = ^{acs_addr[2:0], acs_bytes[7:1], acs_wdata[63:8]};

   assign acs_rdata = rd_status_s
      ? pack_status(fifo_full_s, fifo_empty_s, (state_q != IDLE), ovf_q, 8'(fifo_count_s))
      : 64'h0;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .din_i   (acs_wdata[7:0]),
      .dout_o  (fifo_dout_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .count_o (fifo_count_s)
   );

   // TX framing FSM; the line value is registered, so it trails state by one cycle
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop_s   = 1'b0;
      tx_d    = 1'b1;
      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            baud_d = 16'd0;
            if (!fifo_empty_s) begin
               pop_s   = 1'b1;
               shift_d = fifo_dout_s;
               bit_d   = 3'd0;
               state_d = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            tx_d = 1'b0;
            if (baud_end_s) begin
               baud_d  = 16'd0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         DATA: begin
            tx_d = shift_q[0];
            if (baud_end_s) begin
               baud_d  = 16'd0;
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  state_d = DATA;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         STOP: begin
            tx_d = 1'b1;
            if (baud_end_s) begin
               baud_d  = 16'd0;
               state_d = IDLE;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   // Sticky overflow: a dropped push sets it, a STATUS store with bit 3 clears it
   always_comb begin
      if (push_s && fifo_full_s) begin
         ovf_d = 1'b1;
      end else if (ovf_clr_s) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= 16'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         tx_q    <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule
